// File: rtl/spi_flash_reader_if.sv
// Request/response port between the core fetch path and the boot SPI flash reader.
interface spi_flash_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data, busy);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data, busy);
endinterface

// File: rtl/spi_flash_reader.sv
// Boot-path SPI flash reader: wakes the flash with 0xAB, then serves 32-bit READ (0x03)
// word requests, keeping CSB low to stream sequential words without a new command.
module spi_flash_reader #(
    parameter int CLK_DIV    = 2,
    parameter int RESET_WAIT = 16,
    parameter int CSB_GAP    = 4
) (
    input  logic              clk,
    input  logic              resetn,
    spi_flash_reader_if.slave bus,
    output logic              flash_csb,
    output logic              flash_clk,
    output logic              flash_io0_do,
    output logic              flash_io0_oe,
    input  logic              flash_io1_di
);
    typedef enum logic [2:0] {
        RST_WAIT, PWR_CMD, GAP, IDLE, CMD, DATA, RESP, STREAM
    } state_t;

    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0] PH_HI  = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0] PH_END = PH_W'(2 * CLK_DIV - 1);

    state_t          state, state_nx;
    logic [PH_W-1:0] ph;
    logic [4:0]      bit_cnt;
    logic [15:0]     wait_cnt;
    logic [23:0]     addr, next_addr;
    logic            pend_miss;
    logic [31:0]     rx_sh, tx_word, rsp_data;
    logic            req_ready, rsp_valid;
    logic            accept, hit, bit_end, shifting;

    assign accept   = bus.req_valid && req_ready;
    assign hit      = (bus.req_addr == next_addr);
    assign bit_end  = (ph == PH_END);
    assign shifting = (state == PWR_CMD) || (state == CMD) || (state == DATA);
    assign tx_word  = (state == PWR_CMD) ? 32'hAB00_0000 : {8'h03, addr};

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.busy      = !((state == IDLE) || (state == STREAM));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= RST_WAIT;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RST_WAIT: if (wait_cnt == 16'(RESET_WAIT - 1)) state_nx = PWR_CMD;
            PWR_CMD:  if (bit_end && bit_cnt == 5'd7) state_nx = GAP;
            GAP:      if (wait_cnt == 16'(CSB_GAP - 1)) state_nx = pend_miss ? CMD : IDLE;
            IDLE:     if (accept) state_nx = CMD;
            CMD:      if (bit_end && bit_cnt == 5'd31) state_nx = DATA;
            DATA:     if (bit_end && bit_cnt == 5'd31) state_nx = RESP;
            RESP:     state_nx = STREAM;
            STREAM:   if (accept) state_nx = hit ? DATA : GAP;
            default:  state_nx = RST_WAIT;
        endcase
    end

    // Every state starts with fresh phase, bit and wait counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ph       <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else if (state_nx != state) begin
            ph       <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
            ph       <= bit_end ? '0 : ph + 1'b1;
            if (bit_end) bit_cnt <= bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr      <= '0;
            next_addr <= '0;
            pend_miss <= 1'b0;
            rx_sh     <= '0;
        end else begin
            if (accept) begin
                addr      <= bus.req_addr;
                pend_miss <= (state == STREAM) && !hit;
            end else if (state == CMD) begin
                pend_miss <= 1'b0;
            end
            if (state == DATA && ph == PH_HI) rx_sh <= {rx_sh[30:0], flash_io1_di};
            // 24-bit wrap matches the flash's internal address counter.
            if (state == RESP) next_addr <= addr + 24'd4;
        end
    end

    // Pads and handshake outputs are registered: they follow the state one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flash_csb    <= 1'b1;
            flash_clk    <= 1'b0;
            flash_io0_do <= 1'b0;
            flash_io0_oe <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
        end else begin
            flash_csb    <= !(shifting || state == RESP || state == STREAM);
            flash_clk    <= shifting && (ph >= PH_HI);
            flash_io0_oe <= (state == PWR_CMD) || (state == CMD);
            flash_io0_do <= ((state == PWR_CMD) || (state == CMD)) ? tx_word[5'd31 - bit_cnt] : 1'b0;
            req_ready    <= ((state == IDLE) || (state == STREAM)) && !accept;
            rsp_valid    <= (state == RESP);
            if (state == RESP) rsp_data <= {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural mode-0 SPI flash model.
module tb_spi_flash_reader;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flash_csb, flash_clk, flash_io0_do, flash_io0_oe;
    logic flash_io1_di = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    spi_flash_reader_if bus ();

    spi_flash_reader #(.CLK_DIV(2), .RESET_WAIT(16), .CSB_GAP(4)) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0_do(flash_io0_do),
        .flash_io0_oe(flash_io0_oe), .flash_io1_di(flash_io1_di)
    );

    always #5 clk = ~clk;

    // ---------------- flash model ----------------
    int          bitcnt = 0;
    logic [31:0] rx = '0;
    logic [23:0] rd_addr = '0;
    logic [31:0] last_rd_word = '0;
    logic        is_read = 1'b0;
    logic        powered = 1'b0;
    int          n_ab = 0;
    int          n_rd = 0;
    int          n_csb_rise = 0;
    int          last_tx_bits = 0;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000000: fbyte = 8'hDE;
            24'h000001: fbyte = 8'hAD;
            24'h000002: fbyte = 8'hBE;
            24'h000003: fbyte = 8'hEF;
            24'h000100: fbyte = 8'h11;
            24'h000101: fbyte = 8'h22;
            24'h000102: fbyte = 8'h33;
            24'h000103: fbyte = 8'h44;
            24'h000104: fbyte = 8'h55;
            24'h000105: fbyte = 8'h66;
            24'h000106: fbyte = 8'h77;
            24'h000107: fbyte = 8'h88;
            24'h000200: fbyte = 8'hA1;
            24'h000201: fbyte = 8'hB2;
            24'h000202: fbyte = 8'hC3;
            24'h000203: fbyte = 8'hD4;
            24'hFFFFFC: fbyte = 8'h01;
            24'hFFFFFD: fbyte = 8'h02;
            24'hFFFFFE: fbyte = 8'h03;
            24'hFFFFFF: fbyte = 8'h04;
            default:    fbyte = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge flash_csb) begin
        last_tx_bits = bitcnt;
        if (bitcnt == 8 && rx[7:0] == 8'hAB) begin
            powered = 1'b1;
            n_ab++;
        end
        bitcnt = 0;
        is_read = 1'b0;
        n_csb_rise++;
    end

    always @(posedge flash_clk) begin
        if (flash_csb === 1'b0) begin
            rx = {rx[30:0], flash_io0_do};
            bitcnt++;
            if (bitcnt == 32 && rx[31:24] == 8'h03) begin
                rd_addr = rx[23:0];
                last_rd_word = rx;
                is_read = 1'b1;
                n_rd++;
            end
        end
    end

    always @(negedge flash_clk) begin
        int d;
        logic [7:0] b;
        if (flash_csb === 1'b0 && is_read && bitcnt >= 32) begin
            d = bitcnt - 32;
            b = fbyte(rd_addr + 24'(d / 8));
            flash_io1_di = b[7 - (d % 8)];
        end
    end

    // ---------------- pad monitors ----------------
    logic prev_csb = 1'b1;
    int   gap_len = 0;
    int   last_gap = 0;
    int   sck_viol = 0;

    always @(negedge clk) begin
        if (flash_csb !== prev_csb && flash_clk !== 1'b0) sck_viol++;
        if (flash_csb === 1'b1) gap_len++;
        else begin
            if (prev_csb === 1'b1) last_gap = gap_len;
            gap_len = 0;
        end
        prev_csb = flash_csb;
    end

    // ---------------- request helper ----------------
    task automatic do_read(input logic [23:0] a, output int lat, output logic [31:0] d, output int overlap);
        int n;
        n = 0;
        overlap = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        while (bus.req_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 2000) begin
            if (bus.req_ready === 1'b1) overlap++;
            @(posedge clk); #1; lat++;
        end
        if (bus.req_ready === 1'b1) overlap++;
        d = bus.rsp_data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({flash_csb, flash_clk, flash_io0_do, flash_io0_oe, bus.req_ready, bus.rsp_valid, bus.busy} !== 7'b1000001) begin
            n_fail++;
            $display("FAIL reset_pins: got %b expected 1000001",
                     {flash_csb, flash_clk, flash_io0_do, flash_io0_oe, bus.req_ready, bus.rsp_valid, bus.busy});
        end
        n_tests++;
        if (bus.rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h expected 00000000", bus.rsp_data);
        end
    endtask

    task automatic test_power_up();
        int n, ab0;
        ab0 = n_ab;
        n = 0;
        resetn = 1'b1;
        while (bus.req_ready !== 1'b1 && n < 500) begin
            @(posedge clk); #1; n++;
        end
        n_tests++;
        if (n < 51 || n > 53) begin
            n_fail++;
            $display("FAIL pwr_ready_time: got %0d cycles expected 51..53", n);
        end
        n_tests++;
        if (n_ab !== ab0 + 1 || powered !== 1'b1 || last_tx_bits !== 8) begin
            n_fail++;
            $display("FAIL pwr_cmd_ab: got ab=%0d bits=%0d powered=%b expected ab=%0d bits=8 powered=1",
                     n_ab, last_tx_bits, powered, ab0 + 1);
        end
        n_tests++;
        if (gap_len < 4) begin
            n_fail++;
            $display("FAIL pwr_gap: got %0d expected >=4", gap_len);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pwr_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_single_read();
        int lat, ov, rd0;
        logic [31:0] d;
        rd0 = n_rd;
        do_read(24'h000100, lat, d, ov);
        n_tests++;
        if (lat !== 257) begin
            n_fail++;
            $display("FAIL single_latency: got %0d expected 257", lat);
        end
        n_tests++;
        if (d !== 32'h44332211) begin
            n_fail++;
            $display("FAIL single_data: got %h expected 44332211", d);
        end
        n_tests++;
        if (n_rd !== rd0 + 1 || last_rd_word !== 32'h03000100) begin
            n_fail++;
            $display("FAIL single_cmd: got %h (n=%0d) expected 03000100 (n=%0d)", last_rd_word, n_rd, rd0 + 1);
        end
        n_tests++;
        if (ov !== 0) begin
            n_fail++;
            $display("FAIL single_ready_overlap: got %0d expected 0", ov);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h44332211) begin
            n_fail++;
            $display("FAIL single_pulse_hold: got v=%b d=%h expected v=0 d=44332211", bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_streaming();
        int lat, ov, rd0, rise0;
        logic [31:0] d;
        rd0 = n_rd;
        rise0 = n_csb_rise;
        repeat (20) @(posedge clk);
        #1;
        n_tests++;
        if (flash_csb !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_idle: got csb=%b ready=%b expected csb=0 ready=1", flash_csb, bus.req_ready);
        end
        do_read(24'h000104, lat, d, ov);
        n_tests++;
        if (lat !== 129) begin
            n_fail++;
            $display("FAIL stream_latency: got %0d expected 129", lat);
        end
        n_tests++;
        if (d !== 32'h88776655) begin
            n_fail++;
            $display("FAIL stream_data: got %h expected 88776655", d);
        end
        n_tests++;
        if (n_rd !== rd0 || n_csb_rise !== rise0) begin
            n_fail++;
            $display("FAIL stream_no_cmd: got cmds=%0d rises=%0d expected cmds=%0d rises=%0d", n_rd, n_csb_rise, rd0, rise0);
        end
    endtask

    task automatic test_non_sequential();
        int lat, ov;
        logic [31:0] d;
        do_read(24'h000200, lat, d, ov);
        n_tests++;
        if (lat !== 261) begin
            n_fail++;
            $display("FAIL nonseq_latency: got %0d expected 261", lat);
        end
        n_tests++;
        if (d !== 32'hD4C3B2A1 || last_rd_word !== 32'h03000200) begin
            n_fail++;
            $display("FAIL nonseq_data_cmd: got %h cmd %h expected D4C3B2A1 cmd 03000200", d, last_rd_word);
        end
        n_tests++;
        if (last_gap < 4) begin
            n_fail++;
            $display("FAIL nonseq_gap: got %0d expected >=4", last_gap);
        end
    endtask

    task automatic test_wrap();
        int lat, ov, rd1;
        logic [31:0] d;
        do_read(24'hFFFFFC, lat, d, ov);
        n_tests++;
        if (lat !== 261 || d !== 32'h04030201) begin
            n_fail++;
            $display("FAIL wrap_first: got lat=%0d d=%h expected lat=261 d=04030201", lat, d);
        end
        rd1 = n_rd;
        do_read(24'h000000, lat, d, ov);
        n_tests++;
        if (lat !== 129 || n_rd !== rd1) begin
            n_fail++;
            $display("FAIL wrap_hit: got lat=%0d cmds=%0d expected lat=129 cmds=%0d", lat, n_rd, rd1);
        end
        n_tests++;
        if (d !== 32'hEFBEADDE) begin
            n_fail++;
            $display("FAIL wrap_data: got %h expected EFBEADDE", d);
        end
    endtask

    task automatic test_reset_mid_data();
        int n, ab0, rd0, stray, lat, ov;
        logic [31:0] d;
        ab0 = n_ab;
        rd0 = n_rd;
        stray = 0;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 24'h001234;
        while (bus.req_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!(n_rd == rd0 + 1 && bitcnt >= 41) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        n_tests++;
        if (n >= 2000) begin
            n_fail++;
            $display("FAIL rst_reach_data: got timeout expected 9 data bits clocked");
        end
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({flash_csb, flash_clk, flash_io0_oe, bus.rsp_valid, bus.req_ready, bus.busy} !== 6'b100001) begin
            n_fail++;
            $display("FAIL rst_async_pins: got %b expected 100001",
                     {flash_csb, flash_clk, flash_io0_oe, bus.rsp_valid, bus.req_ready, bus.busy});
        end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 500) begin
            if (bus.rsp_valid === 1'b1) stray++;
            @(posedge clk); #1; n++;
        end
        n_tests++;
        if (stray !== 0 || n_ab !== ab0 + 1) begin
            n_fail++;
            $display("FAIL rst_restart: got stray_rsp=%0d ab=%0d expected stray_rsp=0 ab=%0d", stray, n_ab, ab0 + 1);
        end
        do_read(24'h000100, lat, d, ov);
        n_tests++;
        if (lat !== 257 || d !== 32'h44332211) begin
            n_fail++;
            $display("FAIL rst_reread: got lat=%0d d=%h expected lat=257 d=44332211", lat, d);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        test_reset();
        test_power_up();
        test_single_read();
        test_streaming();
        test_non_sequential();
        test_wrap();
        test_reset_mid_data();
        n_tests++;
        if (sck_viol !== 0) begin
            n_fail++;
            $display("FAIL sck_at_csb_edge: got %0d violations expected 0", sck_viol);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
